dma_copy_ctrl: RTL
==================

# dma_copy_ctrl

- Single-channel memory-to-memory DMA transfer engine sitting directly upstream of the byte-wide `memory` block.
- Drives the memory's `Address`, `MemRead`, `Enable` and `DB_tri` controls and the shared 8-bit `DB_io` bus, so each byte is copied by one read cycle, one capture cycle and one write cycle.
- A host loads source, destination and length, pulses `start`, and waits for a one-cycle `done` (with `error` valid).

## Interface
- `ADDR_MIN`, 64: lowest valid memory address.
- `ADDR_MAX`, 255: highest valid memory address.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  transfer request, sampled only in IDLE.
- `src_addr`  in  8  first source address.
- `dst_addr`  in  8  first destination address.
- `count`  in  8  bytes to copy, 0..255.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky error flag, cleared on next accepted `start`.
- `bytes_left`  out  8  bytes remaining.
- `Address`  out  8  memory address.
- `MemRead`  out  1  1 = read, 0 = write.
- `Enable`  out  1  memory access strobe.
- `DB_tri`  out  1  grants the memory the `DB_io` bus.
- `DB_io`  inout  8  shared data bus; driven by this block only in WR, otherwise Z.

## Operation
- States:
  - IDLE
  - RD: `Enable=1`, `MemRead=1`, `DB_tri=1`, `Address=src_ptr`.
  - CAP: `Enable=0`, `DB_tri=1`, `Address=src_ptr`; latch `DB_io` into `tmp` at the cycle-end edge.
  - WR: `Enable=1`, `MemRead=0`, `DB_tri=0`, `DB_io=tmp`, `Address=dst_ptr`.
  - DONE
- IDLE controls: `Enable=0`, `MemRead=0`, `DB_tri=0`, `Address=8'h00`. DONE uses the same values.
- Controls are a combinational decode of the state and pointer registers.
- `start` accepted in IDLE:
  - latch `src_ptr`, `dst_ptr` and `bytes_left=count`; clear `error`.
  - count=0 → DONE, with no bus activity.
  - range check uses 9-bit sums. If `src_addr<ADDR_MIN`, `dst_addr<ADDR_MIN`, `src_addr+count-1>ADDR_MAX` or `dst_addr+count-1>ADDR_MAX`: set `error`, go to DONE, no bus activity.
  - otherwise go to RD.
- Byte loop is RD → CAP → WR. At the end of WR both pointers increment, `bytes_left` decrements, and the FSM goes to RD if `bytes_left` is still nonzero, else DONE.
- DONE → IDLE after one cycle.
- No pointer wrap: the range check guarantees pointers never pass `ADDR_MAX`.
- Overlapping regions are copied forward byte by byte. For dst>src inside the source window, this replicates the source pattern, which is the defined behaviour.
- `start` in any non-IDLE state, including DONE, is ignored.

## Timing
- Reset values:
  - state IDLE
  - `busy=0`, `done=0`, `error=0`, `bytes_left=0`
  - `tmp=0`, all memory controls 0, `DB_io` Z
- `start` high in cycle 0 → first RD in cycle 1.
- For N bytes: `busy` is high in cycles 1..3N, and `done=1` with `busy=0` in cycle 3N+1.
- count=0 or range error: `done` in cycle 1, `busy` never high.
- `error` is valid in the `done` cycle and holds until the next accepted `start`.
- Memory data appears on `DB_io` after the RD edge. It is sampled at the end of CAP, so the memory's `DB_wrReq` pulse is not needed.
- `reset` mid-transfer: IDLE next cycle, controls deasserted, no further writes. Bytes already written stay written.

## Configuration
- `DMA_VERIFY_EN` defined:
  - Adds VRD and VCAP after WR. VRD is a read of `dst_ptr`; in VCAP, `DB_io` is compared with `tmp`.
  - Pointer update moves from the end of WR to the end of VCAP.
  - Cost is 5 cycles per byte, so `done` is in cycle 5N+1.
  - Mismatch: set `error`, go to DONE immediately; the pointers and `bytes_left` stay at the failing byte.
- Undefined: 3 cycles per byte, no readback.

## Test plan
Memory model preloaded with `mem[i]=i`.
- Basic copy: `src=64`, `dst=128`, `count=4` → `mem[128..131]=64,65,66,67`; `busy` high 12 cycles; `done` in cycle 13; `error=0`; `bytes_left=0`.
- Zero length: `count=0` → `done` in cycle 1; `Enable` never 1; `error=0`.
- Range errors:
  - `src=60`, `count=1` → `error=1`, `done` in cycle 1, no `Enable`.
  - `dst=250`, `count=8` → same response.
- Reset mid-transfer: `src=64`, `dst=128`, `count=4`, `reset` in cycle 5 → `mem[128]=64`, `mem[129]=129` unchanged; all outputs at reset values in cycle 6.
- Ignored start: `start` pulsed in cycle 4 with a different `src` → ignored; transfer finishes with the original values.
- `DMA_VERIFY_EN`:
  - Clean copy of 2 bytes → `done` in cycle 11.
  - Bench forces `DB_io=8'hFF` during the first VCAP → `error=1`, `done` next cycle, `bytes_left=2`.

Source files
------------

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: single-channel memory-to-memory byte copier driving the memory's Address/MemRead/Enable/DB_tri and DB_io bus.
// Optional build macro DMA_VERIFY_EN adds a read-back compare (VRD/VCAP) after every byte write.
module dma_copy_ctrl #(
  parameter int ADDR_MIN = 64,
  parameter int ADDR_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] bytes_left,
  output logic [7:0] Address,
  output logic       MemRead,
  output logic       Enable,
  output logic       DB_tri,
  inout  wire  [7:0] DB_io
);

  // state | meaning
  // IDLE  | waiting for start
  // RD    | memory read strobe at src_ptr
  // CAP   | memory drives DB_io, byte latched into tmp
  // WR    | tmp driven onto DB_io, write strobe at dst_ptr
  // VRD   | read-back strobe at dst_ptr (verify build)
  // VCAP  | read-back compared with tmp (verify build)
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef DMA_VERIFY_EN
  localparam logic [2:0] S_VRD  = 3'd5;
  localparam logic [2:0] S_VCAP = 3'd6;
`endif

  localparam logic [8:0] MIN9 = 9'(ADDR_MIN);
  localparam logic [8:0] MAX9 = 9'(ADDR_MAX);

  logic [2:0] state;
  logic [7:0] src_ptr;
  logic [7:0] dst_ptr;
  logic [7:0] tmp;
  logic [8:0] src_end;
  logic [8:0] dst_end;
  logic       range_err;
  logic       last_byte;

  // 9-bit sums so a long count cannot wrap past the top of memory unnoticed
  assign src_end   = {1'b0, src_addr} + {1'b0, count} - 9'd1;
  assign dst_end   = {1'b0, dst_addr} + {1'b0, count} - 9'd1;
  assign range_err = ({1'b0, src_addr} < MIN9) || ({1'b0, dst_addr} < MIN9) ||
                     (src_end > MAX9) || (dst_end > MAX9);
  assign last_byte = (bytes_left == 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      src_ptr    <= 8'h00;
      dst_ptr    <= 8'h00;
      tmp        <= 8'h00;
      bytes_left <= 8'h00;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            bytes_left <= count;
            error      <= 1'b0;
            if (count == 8'd0) begin
              state <= S_DONE;
            end else if (range_err) begin
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD:  state <= S_CAP;
        S_CAP: begin
          tmp   <= DB_io;
          state <= S_WR;
        end
`ifdef DMA_VERIFY_EN
        S_WR:  state <= S_VRD;
        S_VRD: state <= S_VCAP;
        S_VCAP: begin
          if (DB_io != tmp) begin
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            src_ptr    <= src_ptr + 8'd1;
            dst_ptr    <= dst_ptr + 8'd1;
            bytes_left <= bytes_left - 8'd1;
            state      <= last_byte ? S_DONE : S_RD;
          end
        end
`else
        S_WR: begin
          src_ptr    <= src_ptr + 8'd1;
          dst_ptr    <= dst_ptr + 8'd1;
          bytes_left <= bytes_left - 8'd1;
          state      <= last_byte ? S_DONE : S_RD;
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Address = 8'h00;
    MemRead = 1'b0;
    Enable  = 1'b0;
    DB_tri  = 1'b0;
    case (state)
      S_RD: begin
        Enable  = 1'b1;
        MemRead = 1'b1;
        DB_tri  = 1'b1;
        Address = src_ptr;
      end
      S_CAP: begin
        MemRead = 1'b1;
        DB_tri  = 1'b1;
        Address = src_ptr;
      end
      S_WR: begin
        Enable  = 1'b1;
        Address = dst_ptr;
      end
`ifdef DMA_VERIFY_EN
      S_VRD: begin
        Enable  = 1'b1;
        MemRead = 1'b1;
        DB_tri  = 1'b1;
        Address = dst_ptr;
      end
      S_VCAP: begin
        MemRead = 1'b1;
        DB_tri  = 1'b1;
        Address = dst_ptr;
      end
`endif
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign done  = (state == S_DONE);
  assign DB_io = (state == S_WR) ? tmp : 8'hzz;

endmodule
